// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: round-robin scheduler for a shared 7-segment bus.
// Four hex digits share one active-low segment bus. Each digit owns one slot.
// A slot opens with a blanking gap and then shows the digit. The display data
// is double-buffered and changes only at a frame boundary.
//
// Phase FSM
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_BLANK | leading part of a slot: all enables off, lcd=7F, dp=1
//   ST_SHOW  | rest of the slot: enable cur_digit, drive its decoded value
module seg_scan_ctrl #(
    parameter int CLK_DIV      = 25000,
    parameter int BLANK_CYCLES = 2500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [6:0]  lcd,
    output logic        dp,
    output logic [3:0]  digits,
    output logic [1:0]  cur_digit,
    output logic        frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // The slot timer counts down. A slot starts at TMR_MAX and wraps after zero.
    // The display opens when BLANK_CYCLES cycles of the slot have elapsed.
    localparam logic [CW-1:0] TMR_MAX  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] TMR_SHOW = CW'(CLK_DIV - 1 - BLANK_CYCLES);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tmr, tmr_nxt;
    logic [1:0]    digit_nxt;
    logic [19:0]   shadow, shadow_nxt;
    logic [19:0]   active, active_nxt;
    logic          wrap;
    logic          boundary;
    logic [3:0]    nibble;
    logic [3:0]    lz_mask;
    logic          digit_blank;
    logic [6:0]    lcd_nxt;
    logic          dp_nxt;
    logic [3:0]    digits_nxt;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Next-state, buffer update and registered-output values for the coming edge.
    always_comb begin
        wrap       = (tmr == '0);
        tmr_nxt    = wrap ? TMR_MAX : tmr - 1'b1;
        digit_nxt  = wrap ? cur_digit + 2'd1 : cur_digit;
        boundary   = wrap && (cur_digit == 2'd3);

        // A load on the boundary edge flows straight into active via shadow_nxt.
        shadow_nxt = load ? {dp_in, data_in} : shadow;
        active_nxt = boundary ? shadow_nxt : active;

        state_nxt = state;
        case (state)
            ST_BLANK: if (tmr_nxt == TMR_SHOW) state_nxt = ST_SHOW;
            ST_SHOW:  if (wrap)                state_nxt = ST_BLANK;
            default:                           state_nxt = ST_BLANK;
        endcase

        // lz_mask[k]: nibbles k..3 are all zero. Digit 0 is never blanked.
        lz_mask[3] = (active[15:12] == 4'h0);
        lz_mask[2] = lz_mask[3] && (active[11:8] == 4'h0);
        lz_mask[1] = lz_mask[2] && (active[7:4] == 4'h0);
        lz_mask[0] = 1'b0;

        nibble      = active[4*digit_nxt +: 4];
        digit_blank = blank_lz && lz_mask[digit_nxt];

        lcd_nxt    = 7'h7F;
        dp_nxt     = 1'b1;
        digits_nxt = 4'hF;
        if (state_nxt == ST_SHOW) begin
            digits_nxt = ~(4'b0001 << digit_nxt);
            if (!digit_blank) begin
                lcd_nxt = ~hex_seg(nibble);
                dp_nxt  = ~active[16 + digit_nxt];
            end
        end
    end

    // State, timer, buffers and all outputs update together on the clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_BLANK;
            tmr        <= TMR_MAX;
            cur_digit  <= 2'd0;
            shadow     <= '0;
            active     <= '0;
            lcd        <= 7'h7F;
            dp         <= 1'b1;
            digits     <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            cur_digit  <= digit_nxt;
            shadow     <= shadow_nxt;
            active     <= active_nxt;
            lcd        <= lcd_nxt;
            dp         <= dp_nxt;
            digits     <= digits_nxt;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with CLK_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  lcd;
    logic        dp;
    logic [3:0]  digits;
    logic [1:0]  cur_digit;
    logic        frame_done;

    seg_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .lcd        (lcd),
        .dp         (dp),
        .digits     (digits),
        .cur_digit  (cur_digit),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dpi;
        logic            lz;
        logic [3:0][6:0] lcd;
        logic [3:0]      dpo;
    } vec_t;

    typedef struct {
        logic [3:0] dig;
        logic [6:0] lcd;
        logic       dp;
    } exp_t;

    vec_t vt[8];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic [3:0][6:0] prev_lcd;
    logic [3:0]      prev_dpo;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [3:0] en_pat(input int k);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << k);
    endfunction

    task automatic push_slot(input int k, input logic [6:0] l, input logic d);
        exp_t e;
        e.dig = en_pat(k);
        e.lcd = l;
        e.dp  = d;
        sb.push_back(e);
    endtask

    // Pop the next expected slot, wait for its enable, compare, and time its length.
    task automatic check_slot(input string name);
        exp_t e;
        int   n;
        if (sb.size() == 0) begin
            fail_now({name, "_sb_empty"});
            return;
        end
        e = sb.pop_front();
        n = 0;
        while (digits !== e.dig && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            fail_now({name, "_wait_enable"});
            return;
        end
        chk({name, "_lcd"}, 32'(lcd), 32'(e.lcd));
        chk({name, "_dp"},  32'(dp),  32'(e.dp));
        n = 0;
        while (digits === e.dig && n < 20) begin
            if (lcd !== e.lcd) begin
                chk({name, "_lcd_hold"}, 32'(lcd), 32'(e.lcd));
            end
            tick();
            n++;
        end
        chk({name, "_len"}, 32'(n), 32'd6);
    endtask

    task automatic wait_frame_done(input string name);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        if (n >= 80) fail_now({name, "_frame_done"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vt[1] = '{16'h0070, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1111};
        vt[2] = '{16'h0070, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h78, 7'h40}, 4'b1111};
        vt[3] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vt[4] = '{16'hABCD, 4'b0001, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1110};
        vt[5] = '{16'h89EF, 4'b1010, 1'b1, {7'h00, 7'h10, 7'h06, 7'h0E}, 4'b0101};
        vt[6] = '{16'h0506, 4'b0100, 1'b1, {7'h7F, 7'h12, 7'h40, 7'h02}, 4'b1011};
        vt[7] = '{16'h0001, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h79}, 4'b1111};

        reset    = 1'b1;
        data_in  = 16'h0;
        dp_in    = 4'h0;
        load     = 1'b0;
        blank_lz = 1'b0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_digits", 32'(digits), 32'hF);
            chk("rst_lcd",    32'(lcd),    32'h7F);
            chk("rst_dp",     32'(dp),     32'h1);
            chk("rst_fd",     32'(frame_done), 32'h0);
            chk("rst_cur",    32'(cur_digit),  32'h0);
        end
        reset = 1'b0;

        // Free run: k rising edges after release puts the slot counter at k%8.
        for (int k = 1; k <= 64; k++) begin
            int c;
            int d;
            tick();
            c = k % 8;
            d = (k / 8) % 4;
            chk("run_digits", 32'(digits), (c >= 2) ? 32'(en_pat(d)) : 32'hF);
            chk("run_lcd",    32'(lcd),    (c >= 2) ? 32'h40 : 32'h7F);
            chk("run_cur",    32'(cur_digit), 32'(d));
            chk("run_fd",     32'(frame_done), (c == 0 && d == 0) ? 32'h1 : 32'h0);
            chk("run_onehot", 32'($countones(~digits) <= 1), 32'h1);
        end

        // Table-driven loads at cycle 10 of a frame; old data holds until the boundary.
        prev_lcd = {4{7'h40}};
        prev_dpo = 4'hF;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 9; j++) tick();
            data_in = vt[i].data;
            dp_in   = vt[i].dpi;
            load    = 1'b1;
            tick();
            load    = 1'b0;
            data_in = 16'h0;
            dp_in   = 4'h0;
            push_slot(2, prev_lcd[2], prev_dpo[2]);
            push_slot(3, prev_lcd[3], prev_dpo[3]);
            for (int k = 0; k < 4; k++) push_slot(k, vt[i].lcd[k], vt[i].dpo[k]);
            check_slot("old_d2");
            check_slot("old_d3");
            wait_frame_done("vec");
            blank_lz = vt[i].lz;
            check_slot("vec_d0");
            check_slot("vec_d1");
            check_slot("vec_d2");
            check_slot("vec_d3");
            wait_frame_done("vec_end");
            prev_lcd = vt[i].lcd;
            prev_dpo = vt[i].dpo;
        end

        // Load coincident with the boundary edge bypasses into the next frame.
        for (int j = 0; j < 31; j++) tick();
        chk("bnd_cur",    32'(cur_digit), 32'h3);
        chk("bnd_digits", 32'(digits),    32'h7);
        blank_lz = 1'b0;
        data_in  = 16'hABCD;
        dp_in    = 4'b0001;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        data_in  = 16'h0;
        dp_in    = 4'h0;
        chk("bnd_fd", 32'(frame_done), 32'h1);
        for (int k = 0; k < 4; k++) push_slot(k, vt[4].lcd[k], vt[4].dpo[k]);
        check_slot("bnd_d0");
        check_slot("bnd_d1");
        check_slot("bnd_d2");
        check_slot("bnd_d3");

        // Reset in the middle of digit 2's display window.
        begin
            int n;
            n = 0;
            while (!(digits === 4'b1011 && cur_digit === 2'd2) && n < 64) begin
                tick();
                n++;
            end
            if (n >= 64) fail_now("mid_wait_d2");
        end
        tick();
        reset = 1'b1;
        tick();
        chk("mid_digits", 32'(digits),    32'hF);
        chk("mid_cur",    32'(cur_digit), 32'h0);
        chk("mid_lcd",    32'(lcd),       32'h7F);
        chk("mid_fd",     32'(frame_done), 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) push_slot(k, 7'h40, 1'b1);
        check_slot("mid_d0");
        check_slot("mid_d1");
        check_slot("mid_d2");
        check_slot("mid_d3");
        wait_frame_done("mid");
        for (int k = 0; k < 4; k++) push_slot(k, 7'h40, 1'b1);
        check_slot("mid_shadow_d0");
        check_slot("mid_shadow_d1");
        check_slot("mid_shadow_d2");
        check_slot("mid_shadow_d3");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
